display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexing scan controller for the four-digit seven-segment display. It latches four 2-bit digit values and drives them, with the rotating digit select, into the existing 4:1 digit mux / segment decoder stage. It also produces the active-low anode enables, so that one physical digit is lit at a time. A blanking interval precedes every digit to suppress ghosting.

## Interface

Parameters:
- REFRESH_DIV, default 100000: clock cycles each digit is lit (SHOW time); must be ≥1.
- BLANK_CYCLES, default 1000: clock cycles all anodes are off before each digit (BLANK time); must be ≥1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  scan enable; when low, the display is dark.
- load  input  1  capture strobe for d0_in..d3_in.
- d0_in, d1_in, d2_in, d3_in  input  2 each  new digit values.
- d0, d1, d2, d3  output  2 each  latched digit values, to the mux data inputs.
- sel  output  2  digit select, to the mux select input.
- an  output  4  anode enables, active-low; an[k] lights digit k.
- frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame.

## Operation

- All outputs are registered.
- States:
  - IDLE: scan stopped.
  - BLANK: all anodes off.
  - SHOW: one anode on.
- Counter:
  - Width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)).
  - Cleared on every state change.
- Transitions (checked in priority order):
  - en=0 in any state: next state IDLE, counter=0, sel=0.
  - IDLE with en=1: go to BLANK, sel=0.
  - BLANK: when counter==BLANK_CYCLES-1, go to SHOW; otherwise increment the counter.
  - SHOW: when counter==REFRESH_DIV-1, go to BLANK and set sel=sel+1 (mod 4, so 3 wraps to 0); otherwise increment the counter.
- an is 4'b1111 in IDLE and BLANK. In SHOW, an = ~(4'b0001 << sel).
- frame_done is registered high for exactly one cycle on the SHOW→BLANK edge taken with sel==3. It is 0 otherwise, including when en drops during digit 3.
- load:
  - When load=1 on an edge, d0..d3 take d0_in..d3_in on that edge, in every state.
  - load has no effect on sel, an, the state or the counter.
  - Holding load high captures on every cycle.
- Latched digit values persist through IDLE. Only reset clears them.

## Timing

- Reset values while rst_n=0 at an edge:
  - state=IDLE, counter=0.
  - sel=2'b00, d0..d3=2'b00, an=4'b1111, frame_done=0.
- rst_n has priority over en and load. Reset mid-frame drops to IDLE on the next edge with the latched digits cleared.
- Per-digit period: BLANK_CYCLES+REFRESH_DIV cycles. Frame period: 4×(BLANK_CYCLES+REFRESH_DIV).
- Start-up latency: en sampled high at edge E0 enters BLANK. an first goes low (1110) at edge E0+BLANK_CYCLES.
- sel changes only on BLANK entry. It is therefore stable for the whole SHOW window, and the mux output has settled BLANK_CYCLES cycles before its anode turns on.
- en deassertion: an=1111 and sel=0 from the next edge. Re-enabling always restarts at digit 0 with a full BLANK.
- load captured at edge E is visible on d0..d3 after E, with one-cycle latency. A load during SHOW takes effect within the current SHOW window.

## Test plan

All scenarios use REFRESH_DIV=4 and BLANK_CYCLES=2.

1. **Reset:** rst_n=0 for 3 edges with en=1, load=1, d*_in=2'b11 → sel=0, d0..d3=0, an=1111, frame_done=0 throughout.
2. **Scan order:** release reset; en=1 at edge 0 → an=1111 for 2 cycles, 1110 for 4, 1111 for 2, 1101 for 4, 1111 for 2, 1011 for 4, 1111 for 2, 0111 for 4. sel steps 0,1,2,3 at each BLANK entry.
3. **Frame wrap:** continue from scenario 2 → frame_done high for exactly one cycle at edge 24. sel=0 after that edge, and an=1110 again at edge 26. No second pulse before edge 48.
4. **Load mid-SHOW:** during digit 1 SHOW, pulse load one cycle with d0_in..d3_in=3,2,1,0 → d0..d3=3,2,1,0 on the next edge. sel=1 and an=1101 unchanged; the SHOW window keeps its length.
5. **Disable mid-SHOW:** drop en during digit 2 SHOW → next edge: IDLE, an=1111, sel=0, no frame_done. d0..d3 are retained. Re-assert en → the digit 0 BLANK/SHOW sequence restarts exactly as in scenario 2.
6. **Reset mid-frame:** rst_n=0 for one edge during digit 3 SHOW after a load of 3,3,3,3 → d0..d3=0, an=1111, sel=0, frame_done=0. Scanning restarts from digit 0 only after rst_n=1 with en=1.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexing scan controller for a four-digit seven-segment display.
//   Latches four 2-bit digit values, rotates a digit select through 0..3 and
//   drives active-low anode enables so one digit is lit at a time. Every digit
//   is preceded by a blanking interval (all anodes off) to suppress ghosting.
//
// Parameters
//   REFRESH_DIV  : cycles each digit is lit (>= 1)
//   BLANK_CYCLES : cycles all anodes are off before each digit (>= 1)
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   en           : scan enable; low keeps the display dark
//   load         : capture strobe for d0_in..d3_in
//   d0_in..d3_in : new digit values
//   d0..d3       : latched digit values to the mux data inputs
//   sel          : digit select to the mux select input
//   an           : anode enables, active-low, an[k] lights digit k
//   frame_done   : one-cycle pulse at the end of each 4-digit frame
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] d0_in,
  input  logic [1:0] d1_in,
  input  logic [1:0] d2_in,
  input  logic [1:0] d3_in,
  output logic [1:0] d0,
  output logic [1:0] d1,
  output logic [1:0] d2,
  output logic [1:0] d3,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  // Keep at least one counter bit when both intervals are a single cycle.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_nxt;
  logic [3:0]       r_an;
  logic [3:0]       w_an_nxt;
  logic             r_frame_done;
  logic             w_frame_done_nxt;
  logic [1:0]       r_d0, r_d1, r_d2, r_d3;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_sel_nxt        = r_sel;
    w_frame_done_nxt = 1'b0;
    w_an_nxt         = 4'b1111;

    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_sel_nxt   = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 2'd0;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = S_SHOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            // sel advances on BLANK entry so the mux settles while dark.
            w_state_nxt      = S_BLANK;
            w_cnt_nxt        = '0;
            w_sel_nxt        = r_sel + 2'd1;
            w_frame_done_nxt = (r_sel == 2'd3);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 2'd0;
        end
      endcase
    end

    // Anodes are decoded from the next state so they are registered
    // alongside the state itself.
    if (w_state_nxt == S_SHOW) begin
      w_an_nxt = ~(4'b0001 << w_sel_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_an         <= 4'b1111;
      r_frame_done <= 1'b0;
      r_d0         <= 2'd0;
      r_d1         <= 2'd0;
      r_d2         <= 2'd0;
      r_d3         <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (load) begin
        r_d0 <= d0_in;
        r_d1 <= d1_in;
        r_d2 <= d2_in;
        r_d3 <= d3_in;
      end
    end
  end

  assign d0         = r_d0;
  assign d1         = r_d1;
  assign d2         = r_d2;
  assign d3         = r_d3;
  assign sel        = r_sel;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  localparam int R = 4;
  localparam int B = 2;
  localparam int P = R + B;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [1:0] d0_in, d1_in, d2_in, d3_in;
  logic [1:0] d0, d1, d2, d3;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame_done;

  display_scan_ctrl #(
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .d0_in     (d0_in),
    .d1_in     (d1_in),
    .d2_in     (d2_in),
    .d3_in     (d3_in),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .sel       (sel),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [1:0] sel;
    logic       fd;
    logic [7:0] dig;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_edge   = 0;
  int n_fd     = 0;

  // Reference model: position within the frame counted from BLANK entry
  // of digit 0, rather than an explicit state machine.
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [1:0] m_d [4];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input logic r, input logic e, input logic l,
                      input logic [1:0] a0, input logic [1:0] a1,
                      input logic [1:0] a2, input logic [1:0] a3);
    exp_t x;
    exp_t g;
    int   ph;
    rst_n = r; en = e; load = l;
    d0_in = a0; d1_in = a1; d2_in = a2; d3_in = a3;

    x.an = 4'b1111; x.sel = 2'd0; x.fd = 1'b0;
    if (!r) begin
      m_active = 1'b0;
      for (int k = 0; k < 4; k++) m_d[k] = 2'd0;
    end else begin
      if (l) begin
        m_d[0] = a0; m_d[1] = a1; m_d[2] = a2; m_d[3] = a3;
      end
      if (!e) begin
        m_active = 1'b0;
      end else begin
        if (!m_active) begin
          m_active = 1'b1;
          m_t      = 0;
        end else begin
          m_t++;
        end
        ph    = m_t % (4 * P);
        x.sel = 2'(ph / P);
        if ((ph % P) >= B) x.an = ~(4'b0001 << x.sel);
        x.fd = (ph == 0) && (m_t > 0);
      end
    end
    x.dig = {m_d[3], m_d[2], m_d[1], m_d[0]};
    q.push_back(x);

    @(posedge clk);
    #1;
    n_edge++;
    if (frame_done === 1'b1) n_fd++;
    if (q.size() == 0) begin
      check_eq($sformatf("queue@%0d", n_edge), 8'd0, 8'd1);
    end else begin
      g = q.pop_front();
      check_eq($sformatf("an@%0d", n_edge), {4'd0, an}, {4'd0, g.an});
      check_eq($sformatf("sel@%0d", n_edge), {6'd0, sel}, {6'd0, g.sel});
      check_eq($sformatf("fd@%0d", n_edge), {7'd0, frame_done}, {7'd0, g.fd});
      check_eq($sformatf("dig@%0d", n_edge), {d3, d2, d1, d0}, g.dig);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) m_d[k] = 2'd0;
    rst_n = 1'b0; en = 1'b1; load = 1'b1;
    d0_in = 2'd3; d1_in = 2'd3; d2_in = 2'd3; d3_in = 2'd3;

    // Reset held with en/load active
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 2'd3, 2'd3);

    // Scan order, frame wrap, and a load pulse mid digit-1 SHOW (edge 33)
    for (int i = 0; i < 60; i++) begin
      if (i == 33) step(1'b1, 1'b1, 1'b1, 2'd3, 2'd2, 2'd1, 2'd0);
      else         step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    end
    // edges 60..63: into digit 2 SHOW (SHOW starts at edge 62)
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 2'd1, 2'd1);

    // Disable mid-SHOW, idle a while, digits retained
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 2'd2);

    // Re-enable: fresh digit-0 BLANK; load 3,3,3,3 at edge 10; reset at edge 21
    for (int i = 0; i < 22; i++) begin
      if (i == 10)      step(1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 2'd3, 2'd3);
      else if (i == 21) step(1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 2'd1, 2'd1);
      else              step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    end

    // Out of reset with en=1: scanning restarts from digit 0
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);

    // Frame pulses expected: edges 24 and 48 of the first run only
    check_eq("fd_count", 8'(n_fd), 8'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
